// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage controller and the memory.
interface dmem_access_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              dm_en;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;

    // Controller side: issues requests, receives completions
    modport master (
        output dm_en,
        output dm_wr,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_valid
    );

    // Memory side: receives requests, returns completions
    modport slave (
        input  dm_en,
        input  dm_wr,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_valid
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data access controller: runs one load/store against a variable-latency
// memory, stalling the pipeline until it completes or times out.
module dmem_access_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              stall_n,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    dmem_access_ctrl_if.master dm
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [7:0]        TimeoutCnt = 8'(TIMEOUT);
    localparam logic [DATA_W-1:0] ErrData    = DATA_W'(16'hDEAD);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_inc;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              req;
    logic              timeout;

    assign req     = mem_read | mem_write;
    // Saturating increment so a huge TIMEOUT can never wrap the counter
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign timeout = (cnt_inc >= TimeoutCnt);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dm_valid takes priority over a coincident timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (dm.dm_valid || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; stall is forced off while reset is held
    always_comb begin
        stall_n  = 1'b1;
        dm.dm_en = 1'b0;
        unique case (state_q)
            StIdle:  stall_n = ~req;
            StIssue: begin
                stall_n  = 1'b0;
                dm.dm_en = 1'b1;
            end
            StWait:  stall_n = 1'b0;
            StDone:  stall_n = 1'b1;
            default: stall_n = 1'b1;
        endcase
        if (!rst_n) begin
            stall_n = 1'b1;
        end
    end

    // Request latch, timeout counter, load-data capture and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        op_wr_q <= mem_write;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                    end
                end
                StIssue: cnt_q <= '0;
                StWait: begin
                    cnt_q <= cnt_inc;
                    if (dm.dm_valid) begin
                        if (!op_wr_q) rdata_q <= dm.dm_rdata;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        if (!op_wr_q) rdata_q <= ErrData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm.dm_wr    = op_wr_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign mem_rdata   = rdata_q;
    assign mem_err     = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        stall_n;
    logic [15:0] mem_rdata;
    logic        mem_err;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    dmem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall_n   (stall_n),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .dm        (bus.master)
    );

    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Runs one access from a negedge; memory answers vlat cycles after dm_en (-1 = never).
    // Returns stall-low count, dm_en count, dm_en during DONE and the sampled request.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input int vlat, input logic [15:0] rdv,
                             output int stalls, output int ens, output int en_done,
                             output logic ewr, output logic [15:0] eaddr,
                             output logic [15:0] ewdata, output bit finished);
        int since_en;
        bit seen_en;
        stalls = 0; ens = 0; en_done = 0; finished = 0;
        ewr = 1'b0; eaddr = '0; ewdata = '0;
        since_en = 0; seen_en = 0;
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wdata;
        for (int c = 0; c < 40 && !finished; c++) begin
            bus.dm_valid = seen_en && (vlat >= 0) && (since_en == vlat);
            bus.dm_rdata = bus.dm_valid ? rdv : 16'h0F0F;
            #1;
            if (bus.dm_en) begin
                ens++;
                seen_en = 1;
                since_en = 0;
                ewr = bus.dm_wr; eaddr = bus.dm_addr; ewdata = bus.dm_wdata;
            end
            if (!stall_n) begin
                stalls++;
            end else begin
                finished = 1;
                if (bus.dm_en) en_done++;
            end
            @(negedge clk);
            if (seen_en) since_en++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        bus.dm_valid = 1'b0; bus.dm_rdata = 16'h0F0F;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        bus.dm_valid = 1'b0; bus.dm_rdata = '0;
        #2;
        n_checks++; if (stall_n !== 1'b1) $display("FAIL reset_stall_n: got %b want 1", stall_n); else n_pass++;
        n_checks++; if (bus.dm_en !== 1'b0) $display("FAIL reset_dm_en: got %b want 0", bus.dm_en); else n_pass++;
        n_checks++; if (mem_rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", mem_rdata); else n_pass++;
        n_checks++; if (mem_err !== 1'b0) $display("FAIL reset_err: got %b want 0", mem_err); else n_pass++;
        n_checks++;
        if ({bus.dm_wr, bus.dm_addr, bus.dm_wdata} !== 33'h0)
            $display("FAIL reset_bus: got wr=%b addr=%h wdata=%h want all 0", bus.dm_wr, bus.dm_addr, bus.dm_wdata);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        int st, en, ed; logic w; logic [15:0] a, d; bit f;
        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'h1234, st, en, ed, w, a, d, f);
        n_checks++; if (!f || st != 4) $display("FAIL load_stalls: got %0d (done=%0d) want 4", st, f); else n_pass++;
        n_checks++; if (en != 1 || ed != 0) $display("FAIL load_dm_en: got %0d pulses (%0d in DONE) want 1 (0)", en, ed); else n_pass++;
        n_checks++; if (w !== 1'b0 || a !== 16'h0040) $display("FAIL load_req: got wr=%b addr=%h want wr=0 addr=0040", w, a); else n_pass++;
        n_checks++; if (mem_rdata !== 16'h1234) $display("FAIL load_rdata: got %h want 1234", mem_rdata); else n_pass++;
    endtask

    task automatic test_store();
        int st, en, ed; logic w; logic [15:0] a, d; bit f;
        do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, 16'h5A5A, st, en, ed, w, a, d, f);
        n_checks++; if (!f || st != 3) $display("FAIL store_stalls: got %0d (done=%0d) want 3", st, f); else n_pass++;
        n_checks++;
        if (en != 1 || w !== 1'b1 || a !== 16'h0010 || d !== 16'hBEEF)
            $display("FAIL store_req: got en=%0d wr=%b addr=%h wdata=%h want 1/1/0010/BEEF", en, w, a, d);
        else n_pass++;
        n_checks++; if (mem_rdata !== 16'h1234) $display("FAIL store_rdata: got %h want 1234", mem_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int st1, en1, ed1, st2, en2, ed2; logic w; logic [15:0] a1, a2, d; bit f1, f2;
        logic [15:0] mid;
        do_access(1'b1, 1'b0, 16'h0002, 16'h0000, 1, 16'h00AA, st1, en1, ed1, w, a1, d, f1);
        mid = mem_rdata;
        do_access(1'b1, 1'b0, 16'h0004, 16'h0000, 1, 16'h00BB, st2, en2, ed2, w, a2, d, f2);
        n_checks++; if (mid !== 16'h00AA) $display("FAIL b2b_first_rdata: got %h want 00AA", mid); else n_pass++;
        n_checks++; if (mem_rdata !== 16'h00BB) $display("FAIL b2b_second_rdata: got %h want 00BB", mem_rdata); else n_pass++;
        n_checks++;
        if (en1 + en2 != 2 || ed1 + ed2 != 0)
            $display("FAIL b2b_dm_en: got %0d pulses (%0d in DONE) want 2 (0)", en1 + en2, ed1 + ed2);
        else n_pass++;
        n_checks++;
        if (!f1 || !f2 || st1 != 3 || st2 != 3 || a1 !== 16'h0002 || a2 !== 16'h0004)
            $display("FAIL b2b_timing: got stalls %0d,%0d addr %h,%h want 3,3 0002,0004", st1, st2, a1, a2);
        else n_pass++;
    endtask

    task automatic test_both_high();
        int st, en, ed; logic w; logic [15:0] a, d; bit f;
        do_access(1'b1, 1'b1, 16'h0020, 16'hCAFE, 1, 16'h5555, st, en, ed, w, a, d, f);
        n_checks++; if (en != 1 || w !== 1'b1) $display("FAIL both_op: got en=%0d wr=%b want 1/1", en, w); else n_pass++;
        n_checks++; if (mem_rdata !== 16'h00BB) $display("FAIL both_rdata: got %h want 00BB", mem_rdata); else n_pass++;
    endtask

    task automatic test_stray_valid();
        bit bad_en = 0;
        bit bad_stall = 0;
        for (int c = 0; c < 3; c++) begin
            bus.dm_valid = 1'b1; bus.dm_rdata = 16'h7777;
            #1;
            if (bus.dm_en !== 1'b0) bad_en = 1;
            if (stall_n !== 1'b1) bad_stall = 1;
            @(negedge clk);
        end
        bus.dm_valid = 1'b0;
        n_checks++; if (bad_en || bad_stall) $display("FAIL stray_idle: got en=%0d stall=%0d want 0/0", bad_en, bad_stall); else n_pass++;
        n_checks++; if (mem_rdata !== 16'h00BB) $display("FAIL stray_rdata: got %h want 00BB", mem_rdata); else n_pass++;
    endtask

    task automatic test_timeout();
        int st, en, ed; logic w; logic [15:0] a, d; bit f;
        do_access(1'b1, 1'b0, 16'h0060, 16'h0000, -1, 16'h0000, st, en, ed, w, a, d, f);
        n_checks++; if (!f || st != 17) $display("FAIL timeout_stalls: got %0d (done=%0d) want 17", st, f); else n_pass++;
        n_checks++; if (mem_rdata !== 16'hDEAD) $display("FAIL timeout_rdata: got %h want DEAD", mem_rdata); else n_pass++;
        n_checks++; if (en != 1) $display("FAIL timeout_dm_en: got %0d want 1", en); else n_pass++;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (mem_err !== 1'b1 || stall_n !== 1'b1) $display("FAIL timeout_sticky: got err=%b stall_n=%b want 1/1", mem_err, stall_n); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit bad_en = 0;
        mem_read = 1'b1; mem_addr = 16'h0080;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (stall_n !== 1'b1 || bus.dm_en !== 1'b0) $display("FAIL rst_mid_outputs: got stall_n=%b en=%b want 1/0", stall_n, bus.dm_en); else n_pass++;
        n_checks++; if (mem_err !== 1'b0 || mem_rdata !== 16'h0000) $display("FAIL rst_mid_clear: got err=%b rdata=%h want 0/0000", mem_err, mem_rdata); else n_pass++;
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.dm_valid = 1'b1; bus.dm_rdata = 16'h9999;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.dm_en !== 1'b0) bad_en = 1;
            @(negedge clk);
            bus.dm_valid = 1'b0;
        end
        #1;
        n_checks++; if (mem_rdata !== 16'h0000 || stall_n !== 1'b1) $display("FAIL rst_late_valid: got rdata=%h stall_n=%b want 0000/1", mem_rdata, stall_n); else n_pass++;
        n_checks++; if (bad_en) $display("FAIL rst_no_issue: got dm_en pulse want none"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_both_high();
        test_stray_valid();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
